// File: rtl/matrix_ls_fifo_pkg.sv
// Shared types for the matrix load/store request buffer.
// Holds the request entry layout produced by the matrix LS functional unit
// and the default buffer depth used by the top level.
package matrix_ls_fifo_pkg;

  // Default number of buffered matrix LS requests.
  localparam int MATLS_FIFO_DEPTH = 8;

  // Matrix register index and address widths.
  localparam int MATBITS_W = 3;
  localparam int WORD_W    = 32;

  typedef logic [MATBITS_W-1:0] matbits_t;
  typedef logic [WORD_W-1:0]    word_t;

  // Direction of a matrix memory request.
  typedef enum logic {
    M_LOAD  = 1'b0,
    M_STORE = 1'b1
  } matrix_mem_t;

  // One request as issued by the matrix LS unit toward the scratchpad.
  typedef struct packed {
    matrix_mem_t ls;
    matbits_t    rd;
    word_t       addr;
  } instrFIFO_t;

  localparam int INSTR_FIFO_W = $bits(instrFIFO_t);

  // Pointer width for a circular buffer of the given depth: one extra MSB
  // separates the "wrapped once more" full case from the empty case.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/matrix_ls_fifo_if.sv
// Bundle of the request-buffer signals, shaped like the other
// functional-unit interfaces. The fifo modport is the buffer's view, the
// tb modport is the producer/consumer view.
interface matrix_ls_fifo_if
  import matrix_ls_fifo_pkg::*;
#(
  parameter int DEPTH = MATLS_FIFO_DEPTH
) (
  input logic CLK
);

  logic                     RST;
  logic                     flush;
  logic                     push;
  instrFIFO_t               push_entry;
  logic                     full;
  logic                     sp_valid;
  instrFIFO_t               sp_entry;
  logic                     sp_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport fifo (
    input  CLK, RST, flush, push, push_entry, sp_ready,
    output full, sp_valid, sp_entry, count, overflow
  );

  modport tb (
    input  CLK, full, sp_valid, sp_entry, count, overflow,
    output RST, flush, push, push_entry, sp_ready
  );

endinterface

// File: rtl/matrix_ls_fifo.sv
// In-order request buffer between the matrix LS functional unit and the
// scratchpad request port. Circular storage with first-word fall-through
// from registered pointers; status outputs depend only on registers.
//
// Handshake: the head entry transfers to the scratchpad on a rising edge
// where sp_valid && sp_ready; sp_entry is held stable while sp_valid is
// high and sp_ready is low (flush excepted). On the producer side there is
// no ready signal: the producer samples full before raising push, and a
// push seen while full is dropped and recorded in the sticky overflow flag.
module matrix_ls_fifo
  import matrix_ls_fifo_pkg::*;
#(
  parameter int DEPTH = MATLS_FIFO_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   push,
  input  instrFIFO_t             push_entry,
  output logic                   full,
  output logic                   sp_valid,
  output instrFIFO_t             sp_entry,
  input  logic                   sp_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  instrFIFO_t    mem [DEPTH];

  logic          push_ok;
  logic          pop_ok;

  // Status and head entry, all taken from registered state.
  always_comb begin
    full     = (count_q == DEPTH_P);
    sp_valid = (count_q != '0);
    count    = count_q;
    overflow = overflow_q;
    sp_entry = '0;
    if (sp_valid) begin
      sp_entry = mem[rptr_q[AW-1:0]];
    end
  end

  // Accepted transfers: a full buffer refuses a push even when the head is
  // leaving in the same cycle, so no slot is reused within one edge.
  always_comb begin
    push_ok = push && !full;
    pop_ok  = sp_valid && sp_ready;
  end

  // Next pointer/occupancy state; flush outranks both push and pop but
  // leaves the overflow history intact.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q | (push && full);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rptr_d = rptr_q + PTR_ONE;
      end
    end
    count_d = wptr_d - rptr_d;
  end

  // Pointer, occupancy and sticky overflow registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are never visible while empty, so no reset.
  always_ff @(posedge CLK) begin
    if (push_ok && !flush) begin
      mem[wptr_q[AW-1:0]] <= push_entry;
    end
  end

endmodule

// File: tb/tb_matrix_ls_fifo.sv
// Directed and randomised-handshake bench for matrix_ls_fifo with a
// queue-based reference model and a per-cycle compare process.
module tb_matrix_ls_fifo;
  import matrix_ls_fifo_pkg::*;

  localparam int DEPTH = MATLS_FIFO_DEPTH;
  localparam int W     = $bits(instrFIFO_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  matrix_ls_fifo_if #(.DEPTH(DEPTH)) ifc (.CLK(clk));

  matrix_ls_fifo #(.DEPTH(DEPTH)) dut (
    .CLK        (clk),
    .RST        (ifc.RST),
    .flush      (ifc.flush),
    .push       (ifc.push),
    .push_entry (ifc.push_entry),
    .full       (ifc.full),
    .sp_valid   (ifc.sp_valid),
    .sp_entry   (ifc.sp_entry),
    .sp_ready   (ifc.sp_ready),
    .count      (ifc.count),
    .overflow   (ifc.overflow)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  logic         prev_stall;
  logic [W-1:0] prev_entry;
  int           pushes_acc = 0;
  int           dut_pops   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one rising edge, from the buffer's rules.
  task automatic model_step();
    int  sz;
    bit  do_pop;
    bit  do_push;
    sz         = exp_q.size();
    prev_stall <= ifc.sp_valid && !ifc.sp_ready && !ifc.flush;
    prev_entry <= ifc.sp_entry;
    if (ifc.sp_valid && ifc.sp_ready) dut_pops++;
    if (ifc.push && sz == DEPTH) exp_ovf <= 1'b1;
    if (ifc.flush) begin
      exp_q.delete();
    end else begin
      do_pop  = (sz != 0) && ifc.sp_ready;
      do_push = ifc.push && (sz < DEPTH);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(ifc.push_entry);
        pushes_acc++;
      end
    end
  endtask

  // Model state advances on every edge; reset clears it asynchronously.
  always @(posedge clk or posedge ifc.RST) begin
    if (ifc.RST) begin
      exp_q.delete();
      exp_ovf    <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      model_step();
    end
  end

  // Compare process: every output, every cycle, on the falling edge.
  always @(negedge clk) begin
    chk("count",    64'(ifc.count),    64'(exp_q.size()));
    chk("full",     64'(ifc.full),     64'(exp_q.size() == DEPTH));
    chk("sp_valid", 64'(ifc.sp_valid), 64'(exp_q.size() != 0));
    chk("sp_entry", 64'(ifc.sp_entry), (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'd0);
    chk("overflow", 64'(ifc.overflow), 64'(exp_ovf));
    if (prev_stall && !ifc.RST) chk("stall_stable", 64'(ifc.sp_entry), 64'(prev_entry));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic instrFIFO_t mk(input matrix_mem_t ls, input int rd, input int addr);
    instrFIFO_t e;
    e.ls   = ls;
    e.rd   = matbits_t'(rd);
    e.addr = word_t'(addr);
    return e;
  endfunction

  task automatic drive(input logic p, input instrFIFO_t e, input logic rdy, input logic fl);
    ifc.push       = p;
    ifc.push_entry = e;
    ifc.sp_ready   = rdy;
    ifc.flush      = fl;
  endtask

  instrFIFO_t e_first;
  int         pushes_mark;
  int         pops_mark;

  // ---------------- directed sequence ----------------
  initial begin
    e_first = mk(M_LOAD, 2, 32'h100);
    ifc.RST = 1'b1;
    drive(1'b1, e_first, 1'b0, 1'b0);
    repeat (3) step();
    chk("rst_valid", 64'(ifc.sp_valid), 64'd0);
    chk("rst_count", 64'(ifc.count),    64'd0);
    chk("rst_full",  64'(ifc.full),     64'd0);
    chk("rst_entry", 64'(ifc.sp_entry), 64'd0);
    chk("rst_ovf",   64'(ifc.overflow), 64'd0);

    // First push right after release
    ifc.RST = 1'b0;
    step();
    chk("first_valid", 64'(ifc.sp_valid),      64'd1);
    chk("first_entry", 64'(ifc.sp_entry),      64'(e_first));
    chk("first_addr",  64'(ifc.sp_entry.addr), 64'h100);
    chk("first_count", 64'(ifc.count),         64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("first_drained", 64'(ifc.sp_valid), 64'd0);

    // Fill with no consumer
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk((i % 2) ? M_STORE : M_LOAD, i, i * 4), 1'b0, 1'b0);
      step();
    end
    chk("fill_full",  64'(ifc.full),  64'd1);
    chk("fill_count", 64'(ifc.count), 64'd8);
    drive(1'b1, mk(M_LOAD, 7, 32'h20), 1'b0, 1'b0);
    step();
    chk("ovf_set",   64'(ifc.overflow), 64'd1);
    chk("ovf_count", 64'(ifc.count),    64'd8);

    // Drain in order
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_addr", 64'(ifc.sp_entry.addr), 64'(i * 4));
      step();
    end
    chk("drain_empty", 64'(ifc.sp_valid), 64'd0);
    chk("drain_full",  64'(ifc.full),     64'd0);

    // Streaming one in / one out
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, mk(M_STORE, c % 8, c * 4), 1'b1, 1'b0);
      step();
      chk("stream_count", 64'(ifc.count),         64'd1);
      chk("stream_addr",  64'(ifc.sp_entry.addr), 64'(c * 4));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("stream_empty", 64'(ifc.sp_valid), 64'd0);

    // Asynchronous reset in the middle of operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(M_LOAD, i, 32'h200 + i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_arst_count", 64'(ifc.count),    64'd3);
    chk("pre_arst_ovf",   64'(ifc.overflow), 64'd1);
    #2;
    ifc.RST = 1'b1;
    #1;
    chk("arst_count", 64'(ifc.count),    64'd0);
    chk("arst_valid", 64'(ifc.sp_valid), 64'd0);
    chk("arst_ovf",   64'(ifc.overflow), 64'd0);
    step();
    ifc.RST = 1'b0;
    drive(1'b1, mk(M_LOAD, 1, 32'h40), 1'b0, 1'b0);
    step();
    chk("post_arst_count", 64'(ifc.count),         64'd1);
    chk("post_arst_addr",  64'(ifc.sp_entry.addr), 64'h40);

    // Full with a simultaneous pop: push refused, pop taken
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, mk(M_STORE, i, 32'h40 + i * 4), 1'b0, 1'b0);
      step();
    end
    chk("fp_full", 64'(ifc.full), 64'd1);
    drive(1'b1, mk(M_LOAD, 0, 32'hEE0), 1'b1, 1'b0);
    step();
    chk("fp_count", 64'(ifc.count),         64'd7);
    chk("fp_ovf",   64'(ifc.overflow),      64'd1);
    chk("fp_head",  64'(ifc.sp_entry.addr), 64'h44);

    // Flush at five entries with a push in the same cycle
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) step();
    chk("fl_pre_count", 64'(ifc.count), 64'd5);
    drive(1'b1, mk(M_LOAD, 3, 32'hF00), 1'b0, 1'b1);
    step();
    chk("fl_count", 64'(ifc.count),    64'd0);
    chk("fl_valid", 64'(ifc.sp_valid), 64'd0);
    chk("fl_ovf",   64'(ifc.overflow), 64'd1);
    drive(1'b1, mk(M_STORE, 4, 32'hF04), 1'b0, 1'b0);
    step();
    chk("fl_next_addr",  64'(ifc.sp_entry.addr), 64'hF04);
    chk("fl_next_count", 64'(ifc.count),         64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

    // Random back-pressure against the model
    pushes_mark = pushes_acc;
    pops_mark   = dut_pops;
    for (int c = 0; c < 200; c++) begin
      drive(!ifc.full && ($urandom_range(0, 1) == 1),
            mk(($urandom_range(0, 1) == 1) ? M_STORE : M_LOAD,
               int'($urandom_range(0, 7)), int'($urandom)),
            ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1, 1'b0);
      if (c % 3 == 0) ifc.sp_ready = 1'b1;
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (DEPTH + 1) step();
    chk("rand_empty",    64'(ifc.sp_valid), 64'd0);
    chk("rand_lossless", 64'(dut_pops - pops_mark), 64'(pushes_acc - pushes_mark));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
